fa_3_chunk_seq: RTL

//  Multi-cycle wide adder built around the 3-bit fa_3 slice: accepts two
//  W=3*NCHUNK-bit operands plus carry-in over a valid/ready handshake.

---
 rtl/fa_3_chunk_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fa_3_chunk_seq.sv
// Multi-cycle W=3*NCHUNK-bit adder: feeds one 3-bit chunk per clock (LSB first)
// through a single fa_3 slice, carrying between chunks, with valid/ready on both sides.

module fa_3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] s,
    output logic       cout
);
    logic [3:0] w_total;

    assign w_total = {1'b0, a} + {1'b0, b} + {3'b000, cin};
    assign s       = w_total[2:0];
    assign cout    = w_total[3];
endmodule

module fa_3_chunk_seq #(
    parameter int NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*NCHUNK-1:0]   a,
    input  logic [3*NCHUNK-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*NCHUNK-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);
    localparam int W  = 3 * NCHUNK;
    localparam int IW = $clog2(NCHUNK + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [2:0]      w_s;
    logic            w_cout;
    logic [W-1:0]    w_sum_next;

    fa_3 u_fa_3 (
        .a    (r_a[2:0]),
        .b    (r_b[2:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Each new chunk enters at the top so the LSB chunk ends up at the bottom.
    generate
        if (NCHUNK == 1) begin : g_single
            assign w_sum_next = w_s;
        end else begin : g_multi
            assign w_sum_next = {w_s, r_sum[W-1:3]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_a     <= r_a >> 3;
                    r_b     <= r_b >> 3;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_cout      <= w_cout;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idx       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule
